// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types, window-offset constants and address-width helper
// for the CNN pooling stages.
package cnn_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT1, WAIT2, CAPTURE, WRITE, FINISH} pool_st_e;
  localparam logic [1:0] WIN_TL = 2'd0;
  localparam logic [1:0] WIN_TR = 2'd1;
  localparam logic [1:0] WIN_BL = 2'd2;
  localparam logic [1:0] WIN_BR = 2'd3;
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: channel-major address mapping for 2x2 stride-2 pooling;
// k[1] selects the window row and k[0] the window column.
module pool_addr_gen import cnn_pkg::*; #(
  parameter int CHANNELS = 8,
  parameter int IMG_SIZE = 28,
  localparam int OUT = IMG_SIZE / 2,
  localparam int AW_IN = addr_w(CHANNELS * IMG_SIZE * IMG_SIZE),
  localparam int AW_OUT = addr_w(CHANNELS * OUT * OUT),
  localparam int CW = addr_w(CHANNELS),
  localparam int OW = addr_w(OUT)
) (
  input  logic [CW-1:0]     c_i,
  input  logic [OW-1:0]     oy_i,
  input  logic [OW-1:0]     ox_i,
  input  logic [1:0]        k_i,
  output logic [AW_IN-1:0]  in_addr_o,
  output logic [AW_OUT-1:0] out_addr_o
);
  assign in_addr_o = AW_IN'(32'(c_i) * IMG_SIZE * IMG_SIZE
                     + (2 * 32'(oy_i) + 32'(k_i[1])) * IMG_SIZE
                     + 2 * 32'(ox_i) + 32'(k_i[0]));
  assign out_addr_o = AW_OUT'(32'(c_i) * OUT * OUT + 32'(oy_i) * OUT + 32'(ox_i));
endmodule

// File: rtl/maxpool2x2.sv
// maxpool2x2: 2x2 stride-2 signed max pooling from the conv BRAM into the pool BRAM.
// Define MAXPOOL_FUSED_RELU_EN to clamp negative maxima to zero on write.
module maxpool2x2 import cnn_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS = 8,
  parameter int IMG_SIZE = 28,
  localparam int OUT = IMG_SIZE / 2,
  localparam int AW_IN = addr_w(CHANNELS * IMG_SIZE * IMG_SIZE),
  localparam int AW_OUT = addr_w(CHANNELS * OUT * OUT),
  localparam int CW = addr_w(CHANNELS),
  localparam int OW = addr_w(OUT)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic [AW_IN-1:0]             conv_r_addr,
  output logic                         conv_r_en,
  input  logic signed [DATA_WIDTH-1:0] conv_r_q,
  output logic [AW_OUT-1:0]            pool_w_addr,
  output logic                         pool_w_en,
  output logic                         pool_w_we,
  output logic signed [DATA_WIDTH-1:0] pool_w_d,
  output logic                         done
);
  if (IMG_SIZE < 2 || IMG_SIZE % 2 != 0) begin : g_bad_size
    $error("maxpool2x2: IMG_SIZE must be even and >= 2");
  end
  pool_st_e                      st_q;
  logic [CW-1:0]                 c_q;
  logic [OW-1:0]                 oy_q, ox_q;
  logic [1:0]                    k_q;
  logic signed [DATA_WIDTH-1:0]  max_q, max_d;
  logic                          done_q, last_ox, last_oy, last_c;
  pool_addr_gen #(.CHANNELS(CHANNELS), .IMG_SIZE(IMG_SIZE)) u_addr (
    .c_i(c_q), .oy_i(oy_q), .ox_i(ox_q), .k_i(k_q),
    .in_addr_o(conv_r_addr), .out_addr_o(pool_w_addr)
  );
  assign last_ox = ox_q == OW'(OUT - 1);
  assign last_oy = oy_q == OW'(OUT - 1);
  assign last_c = c_q == CW'(CHANNELS - 1);
  // strict compare so ties keep the earlier window element
  assign max_d = (k_q == WIN_TL || conv_r_q > max_q) ? conv_r_q : max_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      c_q <= '0;
      oy_q <= '0;
      ox_q <= '0;
      k_q <= '0;
      max_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        IDLE: if (start) begin
          c_q <= '0;
          oy_q <= '0;
          ox_q <= '0;
          k_q <= '0;
          st_q <= ISSUE;
        end
        ISSUE: st_q <= WAIT1;
        WAIT1: st_q <= WAIT2;
        WAIT2: st_q <= CAPTURE;
        CAPTURE: begin
          max_q <= max_d;
          k_q <= k_q + 2'd1;
          st_q <= (k_q == WIN_BR) ? WRITE : ISSUE;
        end
        WRITE: begin
          ox_q <= last_ox ? '0 : ox_q + 1'b1;
          if (last_ox) oy_q <= last_oy ? '0 : oy_q + 1'b1;
          if (last_ox && last_oy) c_q <= last_c ? '0 : c_q + 1'b1;
          st_q <= (last_ox && last_oy && last_c) ? FINISH : ISSUE;
        end
        FINISH: begin
          done_q <= 1'b1;
          st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  assign conv_r_en = st_q == ISSUE;
  assign pool_w_en = st_q == WRITE;
  assign pool_w_we = st_q == WRITE;
  assign done = done_q;
`ifdef MAXPOOL_FUSED_RELU_EN
  assign pool_w_d = max_q[DATA_WIDTH-1] ? '0 : max_q;
`else
  assign pool_w_d = max_q;
`endif
endmodule

// File: tb/tb_maxpool2x2.sv
// tb_maxpool2x2: directed checks of maxpool2x2 on a 1-channel and a 2-channel 4x4 build.
module tb_maxpool2x2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [3:0] raddr0;
  logic [1:0] waddr0;
  logic [4:0] raddr1;
  logic [2:0] waddr1;
  logic r_en0, w_en0, w_we0, done0, r_en1, w_en1, w_we1, done1;
  logic signed [15:0] q0, d0, q1, d1;
  logic signed [15:0] mem0 [16];
  logic signed [15:0] pool0 [4];
  logic signed [15:0] mem1 [32];
  logic signed [15:0] pool1 [8];
  int wcnt0 = 0, dcnt0 = 0, wcnt1 = 0, dcnt1 = 0, rmax1 = 0, wmax1 = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  maxpool2x2 #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_SIZE(4)) u0 (
    .clk(clk), .reset(reset), .start(start0),
    .conv_r_addr(raddr0), .conv_r_en(r_en0), .conv_r_q(q0),
    .pool_w_addr(waddr0), .pool_w_en(w_en0), .pool_w_we(w_we0), .pool_w_d(d0),
    .done(done0)
  );
  maxpool2x2 #(.DATA_WIDTH(16), .CHANNELS(2), .IMG_SIZE(4)) u1 (
    .clk(clk), .reset(reset), .start(start1),
    .conv_r_addr(raddr1), .conv_r_en(r_en1), .conv_r_q(q1),
    .pool_w_addr(waddr1), .pool_w_en(w_en1), .pool_w_we(w_we1), .pool_w_d(d1),
    .done(done1)
  );
  always @(posedge clk) begin
    if (r_en0) q0 <= mem0[raddr0];
    if (w_en0 && w_we0) begin
      pool0[waddr0] <= d0;
      wcnt0 <= wcnt0 + 1;
    end
    if (done0) dcnt0 <= dcnt0 + 1;
    if (r_en1) q1 <= mem1[raddr1];
    if (r_en1 && int'(raddr1) > rmax1) rmax1 <= int'(raddr1);
    if (w_en1 && w_we1) begin
      pool1[waddr1] <= d1;
      wcnt1 <= wcnt1 + 1;
      if (int'(waddr1) > wmax1) wmax1 <= int'(waddr1);
    end
    if (done1) dcnt1 <= dcnt1 + 1;
  end
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  // pulse start on one DUT and count edges until its done; noisy re-pulses start mid-run
  task automatic run(input int sel, input bit noisy, output int lat);
    lat = 0;
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    start1 = 1'b0;
    for (int n = 1; n <= 400 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if ((sel == 0) ? done0 : done1) lat = n;
      else if (noisy) start1 = (n % 7 == 3 && n < 120);
    end
    start1 = 1'b0;
  endtask
  initial begin
    int lat, w, d;
    int exp1 [8];
    logic signed [15:0] win [16];
    for (int i = 0; i < 16; i++) mem0[i] = 16'(i);
    for (int i = 0; i < 16; i++) mem1[i] = 16'(i);
    for (int i = 16; i < 32; i++) mem1[i] = 16'sd100;
    mem1[21] = 16'sd200;
    mem1[23] = 16'sd200;
    mem1[29] = 16'sd200;
    mem1[31] = 16'sd200;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", done0, 0);
    chk("rst_ren", r_en0, 0);
    chk("rst_wen", w_en0, 0);
    chk("rst_raddr", raddr0, 0);
    chk("rst_waddr", waddr0, 0);
    reset = 1'b0;
    w = wcnt0;
    d = dcnt0;
    run(0, 1'b0, lat);
    chk("ramp_lat", lat, 69);
    @(posedge clk);
    #1 chk("ramp_done_1cyc", done0, 0);
    repeat (3) @(posedge clk);
    #1 chk("ramp_dcnt", dcnt0 - d, 1);
    chk("ramp_wcnt", wcnt0 - w, 4);
    chk("ramp_p0", pool0[0], 5);
    chk("ramp_p1", pool0[1], 7);
    chk("ramp_p2", pool0[2], 13);
    chk("ramp_p3", pool0[3], 15);
    win = '{-16'sd3, -16'sd1, -16'sd32768, 16'sd32767,
            -16'sd7, -16'sd2, 16'sd0, -16'sd1,
            16'sd4, 16'sd4, 16'sd9, -16'sd5,
            16'sd4, 16'sd4, 16'sd9, 16'sd1};
    for (int i = 0; i < 16; i++) mem0[i] = win[i];
    w = wcnt0;
    run(0, 1'b0, lat);
    chk("win_lat", lat, 69);
    repeat (2) @(posedge clk);
    #1 chk("win_wcnt", wcnt0 - w, 4);
`ifdef MAXPOOL_FUSED_RELU_EN
    chk("win_neg", pool0[0], 0);
`else
    chk("win_neg", pool0[0], -1);
`endif
    chk("win_extreme", pool0[1], 32767);
    chk("win_equal", pool0[2], 4);
    chk("win_tie", pool0[3], 9);
    exp1 = '{5, 7, 13, 15, 200, 200, 200, 200};
    w = wcnt1;
    d = dcnt1;
    run(1, 1'b0, lat);
    chk("c2_lat", lat, 137);
    repeat (3) @(posedge clk);
    #1 chk("c2_wcnt", wcnt1 - w, 8);
    chk("c2_dcnt", dcnt1 - d, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("c2_p%0d", i), pool1[i], exp1[i]);
    chk("c2_rmax", rmax1, 31);
    chk("c2_wmax", wmax1, 7);
    w = wcnt1;
    d = dcnt1;
    run(1, 1'b1, lat);
    chk("noisy_lat", lat, 137);
    repeat (5) @(posedge clk);
    #1 chk("noisy_wcnt", wcnt1 - w, 8);
    chk("noisy_dcnt", dcnt1 - d, 1);
    w = wcnt1;
    d = dcnt1;
    run(1, 1'b0, lat);
    chk("rerun_lat", lat, 137);
    repeat (3) @(posedge clk);
    #1 chk("rerun_wcnt", wcnt1 - w, 8);
    chk("rerun_dcnt", dcnt1 - d, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("rerun_p%0d", i), pool1[i], exp1[i]);
    for (int i = 0; i < 16; i++) mem1[i] = 16'(i + 1000);
    mem1[21] = 16'sd300;
    mem1[23] = 16'sd300;
    mem1[29] = 16'sd300;
    mem1[31] = 16'sd300;
    exp1 = '{1005, 1007, 1013, 1015, 300, 300, 300, 300};
    w = wcnt1;
    d = dcnt1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("abort_ren", r_en1, 0);
    chk("abort_wen", w_en1, 0);
    chk("abort_done", done1, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("abort_wcnt", wcnt1 - w, 1);
    chk("abort_dcnt", dcnt1 - d, 0);
    w = wcnt1;
    run(1, 1'b0, lat);
    chk("post_lat", lat, 137);
    repeat (3) @(posedge clk);
    #1 chk("post_wcnt", wcnt1 - w, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("post_p%0d", i), pool1[i], exp1[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxpool2x2.md
Name: maxpool2x2

Overview:
- 2x2, stride-2 max-pooling stage that runs directly after the in-place ReLU pass over the conv feature-map BRAM.
- Reads the conv buffer through a synchronous-read port and writes the pooled maps into a separate pool BRAM through a write port.
- Started by a one-cycle `start` pulse from the top-level sequencer; signals completion with a one-cycle `done` pulse.
- Feeds the flatten/dense stage.

Parameters:
- DATA_WIDTH, 16, signed element width.
- CHANNELS, 8, number of feature maps.
- IMG_SIZE, 28, input map side length; must be even and at least 2, otherwise elaboration fails with $error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle run request
- conv_r_addr  out  AW_IN=$clog2(CHANNELS*IMG_SIZE^2)  conv BRAM read address
- conv_r_en  out  1  conv BRAM read enable
- conv_r_q  in  DATA_WIDTH signed  conv BRAM read data, latency 1
- pool_w_addr  out  AW_OUT=$clog2(CHANNELS*(IMG_SIZE/2)^2)  pool BRAM write address
- pool_w_en  out  1  pool BRAM enable
- pool_w_we  out  1  pool BRAM write enable
- pool_w_d  out  DATA_WIDTH signed  pooled value
- done  out  1  one-cycle completion pulse

Behaviour:
- Memory layout is channel-major.
  - Input address = c*IMG_SIZE^2 + y*IMG_SIZE + x.
  - Output address = c*OUT^2 + oy*OUT + ox, with OUT=IMG_SIZE/2.
- Counters c, oy, ox and window index k (0..3) are registered. Window element k reads (2oy+k[1], 2ox+k[0]), i.e. in the order TL, TR, BL, BR.
- FSM states: IDLE, ISSUE, WAIT1, WAIT2, CAPTURE, WRITE, FINISH.
  - IDLE: on `start`, clear all counters and go to ISSUE.
  - ISSUE: conv_r_en=1 with the address of window element k; go to WAIT1. conv_r_en is high only in ISSUE.
  - WAIT1 -> WAIT2 -> CAPTURE. conv_r_q is sampled only in CAPTURE.
  - CAPTURE: max_reg <= (k==0) ? conv_r_q : signed max(max_reg, conv_r_q). If k<3, increment k and go to ISSUE; else clear k and go to WRITE.
  - WRITE: pool_w_en = pool_w_we = 1, pool_w_addr = current output address, pool_w_d = max_reg. Then advance ox, then oy, then c (ripple). After the last output go to FINISH, else go to ISSUE.
  - FINISH: done <= 1 for exactly one cycle; go to IDLE.
- Comparison is full-width signed; ties keep the earlier value. There is no saturation or width growth.
- Timing: 17 cycles per output.
  - Total run = 17*CHANNELS*OUT^2 + 1 cycles of non-IDLE state.
  - done is high in the cycle after FINISH.
- `start` outside IDLE is ignored. `start` held high re-triggers only after returning to IDLE.
- Reset:
  - Values: st=IDLE, done=0, all counters 0, max_reg=0.
  - The address outputs therefore read 0 and all enables are low.
  - Reset mid-run aborts immediately. No further reads or writes occur; the partially written pool buffer is left as is.
- Output addresses never exceed CHANNELS*OUT^2-1. Read addresses never exceed CHANNELS*IMG_SIZE^2-1.

Optional Feature:
- Macro MAXPOOL_FUSED_RELU_EN.
  - Defined: pool_w_d = (max_reg < 0) ? 0 : max_reg. This lets the sequencer skip the separate ReLU pass. Timing is unchanged.
  - Undefined: pool_w_d = max_reg unmodified, so negative maxima pass through.

Decomposition:
- Shared package cnn_pkg holds:
  - address-width helper function, with a width of 1 when N<=1
  - pool state enum typedef
  - window-offset constants for TL, TR, BL, BR
- One sub-module, pool_addr_gen: purely combinational. Maps (c, oy, ox, k) to the input address and (c, oy, ox) to the output address.
- The FSM, counters and comparator stay in maxpool2x2.

Test Plan:
- CHANNELS=1, IMG_SIZE=4, conv buffer 0..15 ramp -> writes 5,7,13,15 to addrs 0..3. done pulses exactly once, 69 edges after the edge sampling start.
- Single window -3,-1,-7,-2 -> writes -1 without the macro; writes 0 with MAXPOOL_FUSED_RELU_EN.
- Extremes window -32768, 32767, 0, -1 -> 32767. Window 4,4,4,4 -> 4.
- CHANNELS=2, IMG_SIZE=4, channel 1 all 100 plus per-window max 200 at BR -> addrs 4..7 hold 200. No write address exceeds 7; no read address exceeds 31.
- start pulsed repeatedly mid-run -> ignored, exactly 8 writes, single done. A new start after done reruns with identical results.
- reset asserted 20 cycles into a run -> next cycle all enables 0 and done 0. A following start produces the full correct output.
